// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default frame geometry.
// Imported by uart_rx and uart_tx so both ends agree on the constants.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DATA_BITS  = 8;

  // 2-of-3 vote used when majority sampling is built in.
  function automatic logic maj3(
    input logic a,
    input logic b,
    input logic c
  );
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous bit.
// Ports: clk_i, rst_ni (sync, active-low), d_i (async in), q_o (synced out).
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [1:0] ff_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      ff_q <= {2{RESET_VAL}};
    end else begin
      ff_q <= {ff_q[0], d_i};
    end
  end

  assign q_o = ff_q[1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver: oversampled start/data/stop framing, LSB first.
// Ports: clk, rst (sync, active-low), b_tick (oversample strobe), rx (line),
//   rx_data (last good byte), rx_done / frame_err (1-clk pulses), rx_busy.
// Build option: UART_RX_MAJORITY_EN -> 2-of-3 vote around each sample point.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DATA_BITS  = UART_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 b_tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 frame_err
);

  localparam int TW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] T_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] B_LAST = BW'(DATA_BITS - 1);

`ifdef UART_RX_MAJORITY_EN
  // Start decision moves one tick later so the vote window is centred
  // on mid start bit; every later decision inherits that offset, so the
  // data/stop windows stay centred at tick_cnt LAST-1 with no extra math.
  localparam logic [TW-1:0] T_START = T_MID + 1'b1;
`else
  localparam logic [TW-1:0] T_START = T_MID;
`endif

  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] sr_q, sr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 rx_s;
  logic                 sample;

  sync_2ff #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk_i  (clk),
    .rst_ni (rst),
    .d_i    (rx),
    .q_o    (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  // Last two per-tick samples; with the current rx_s they form the window.
  logic [1:0] vote_q, vote_d;

  always_comb begin
    vote_d = vote_q;
    if (b_tick) begin
      vote_d = {vote_q[0], rx_s};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vote_q <= 2'b11;
    end else begin
      vote_q <= vote_d;
    end
  end

  assign sample = maj3(vote_q[1], vote_q[0], rx_s);
`else
  assign sample = rx_s;
`endif

  always_comb begin
    state_d = state_q;
    tick_d  = tick_q;
    bit_d   = bit_q;
    sr_d    = sr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          tick_d  = '0;
        end
      end

      START: begin
        if (b_tick) begin
          if (tick_q == T_START) begin
            tick_d = '0;
            bit_d  = '0;
            state_d = sample ? IDLE : DATA;
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (b_tick) begin
          if (tick_q == T_LAST) begin
            tick_d = '0;
            sr_d   = sr_q >> 1;
            sr_d[DATA_BITS-1] = sample;
            if (bit_q == B_LAST) begin
              state_d = STOP;
            end else begin
              bit_d = bit_q + 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (b_tick) begin
          if (tick_q == T_LAST) begin
            // Leaving at mid stop bit lets an immediate next start
            // edge be caught without any idle time.
            tick_d  = '0;
            state_d = IDLE;
            if (sample) begin
              data_d = sr_q;
              done_d = 1'b1;
            end else begin
              err_d = 1'b1;
            end
          end else begin
            tick_d = tick_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tick_q  <= '0;
      bit_q   <= '0;
      sr_q    <= '0;
      data_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tick_q  <= tick_d;
      bit_q   <= bit_d;
      sr_q    <= sr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = err_q;
  assign rx_busy   = (state_q != IDLE);

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter OVERSAMPLE, default 16, meaning b_tick pulses per bit period.
REQ-002 The block SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (rx_data width).
REQ-003 The block SHALL have port clk, input, 1, system clock (100 MHz); all logic on rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous, active-low (0 = reset).
REQ-005 The block SHALL have port b_tick, input, 1, one-clk-wide oversample pulse at BAUD*OVERSAMPLE rate from the shared baud generator.
REQ-006 The block SHALL have port rx, input, 1, asynchronous serial line, idle high.
REQ-007 The block SHALL have port rx_data, output, DATA_BITS, last correctly framed byte, LSB received first.
REQ-008 The block SHALL have port rx_done, output, 1, one-clk pulse when rx_data is updated.
REQ-009 The block SHALL have port rx_busy, output, 1, high whenever state is not IDLE.
REQ-010 The block SHALL have port frame_err, output, 1, one-clk pulse when the sampled stop bit is 0.

Function
REQ-011 rx SHALL pass through a 2-FF synchronizer (both FFs reset to 1); the FSM sees only rx_s, 2 clk late.
REQ-012 FSM states SHALL be IDLE, START, DATA, STOP; tick_cnt counts b_tick pulses 0..OVERSAMPLE-1, bit_cnt counts 0..DATA_BITS-1.
REQ-013 IDLE: on rx_s==0, go to START with tick_cnt=0; b_tick not required for this transition.
REQ-014 START: on the b_tick that makes tick_cnt reach OVERSAMPLE/2-1 (mid start bit), sample; if 0 go to DATA with tick_cnt=0, bit_cnt=0; if 1 (glitch) go to IDLE with no output pulse.
REQ-015 DATA: on every OVERSAMPLE-th b_tick (tick_cnt==OVERSAMPLE-1), shift the sample into shift register bit DATA_BITS-1 (right shift, LSB first), clear tick_cnt; after bit DATA_BITS-1, go to STOP.
REQ-016 STOP: at the OVERSAMPLE-th b_tick, sample; 1 -> rx_data<=shift register and rx_done=1 for that clk; 0 -> frame_err=1 for that clk, rx_data unchanged; both cases return to IDLE the same edge.
REQ-017 Return to IDLE at mid stop bit SHALL permit a following start bit to be detected with no idle gap.
REQ-018 rx_done and frame_err SHALL never be high in the same cycle, and each SHALL be exactly one clk wide.
REQ-019 Cycles without b_tick SHALL hold tick_cnt, bit_cnt, state (except REQ-013).
REQ-020 rx_data SHALL hold its value until the next good frame.

Reset
REQ-021 With rst==0 at a clk edge: state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0, rx_data=0, rx_done=0, frame_err=0, rx_busy=0, synchronizer FFs=1.
REQ-022 Reset mid-frame SHALL abort the frame with no rx_done/frame_err pulse; reception resumes on the next falling edge after release.

Configuration
REQ-023 Macro UART_RX_MAJORITY_EN defined: each start/data/stop sample SHALL be the 2-of-3 majority of rx_s at tick_cnt values mid-1, mid, mid+1 (mid = sample tick of REQ-014/015/016), decision taken at tick mid+1.
REQ-024 Macro UART_RX_MAJORITY_EN undefined: single sample at the tick of REQ-014/015/016; no vote logic synthesized.

Structure
REQ-025 A shared package uart_pkg SHALL hold the state encoding (IDLE=0, START=1, DATA=2, STOP=3) and default OVERSAMPLE/DATA_BITS constants, shared with uart_tx.
REQ-026 The 2-FF synchronizer SHALL be the single sub-module sync_2ff; everything else is flat in uart_rx.

Verification
Bench: 100 MHz clk, b_tick every 651 clk (9600 baud x16), bit period 104_160 ns.
REQ-027 Frame 0x41 with stop=1 -> rx_data=0x41, one rx_done pulse ~9.5 bit periods after the start falling edge, frame_err never high.
REQ-028 rx low for 3 ticks then high -> returns to IDLE, rx_busy drops, no rx_done, no frame_err, rx_data unchanged.
REQ-029 Frame 0x3C with stop=0 -> one frame_err pulse, no rx_done, rx_data keeps previous value.
REQ-030 Back-to-back 0x55 then 0xAA, no idle gap -> two rx_done pulses, rx_data 0x55 then 0xAA.
REQ-031 rst=0 for 2 clk during bit 4 of a frame -> all outputs reset per REQ-021, no pulse; next frame 0xF0 received correctly.
REQ-032 Loopback uart_tx.uart_tx->rx, tx_data=0x41, shared b_tick; with UART_RX_MAJORITY_EN, 1-tick glitch mid data bit -> rx_data=0x41, rx_done once.
